l2_read_arbiter: RTL and testbench
==================================

Name: l2_read_arbiter

Overview:
- Shares the single L2 read port between the L1 instruction cache refill path and the L1 data cache refill path.
- Sits between the fetch-stage icache and memory-stage dcache, which are its requesters, and the L2 cache.
- Serialises block reads, latches the granted address, and routes the returned 256-bit block to the winner.
- Arbitration is round-robin; an abandoned transaction is completed and its data discarded.

Parameters:
- ADDR_W, 32, byte address width.
- BLOCK_W, 256, refill block width in bits; block is BLOCK_W/8 bytes.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_re  in  1  icache refill request; level, held until done
- i_addr  in  ADDR_W  icache refill address
- i_block  out  BLOCK_W  block returned to icache
- i_stall  out  1  high while icache request is pending or in flight
- d_re  in  1  dcache refill request
- d_addr  in  ADDR_W  dcache refill address
- d_block  out  BLOCK_W  block returned to dcache
- d_stall  out  1  high while dcache request is pending or in flight
- l2_re  out  1  read enable to L2
- l2_addr  out  ADDR_W  block-aligned address to L2
- l2_block  in  BLOCK_W  L2 read data
- l2_stall  in  1  L2 busy

Behaviour:
- L2 protocol:
  - l2_re/l2_addr are held stable until a completion cycle, defined as l2_re=1 and l2_stall=0.
  - l2_block is valid only in the completion cycle.
- Requester protocol:
  - Requester X has data in a cycle where X_re=1 and X_stall=0; X_block is valid in that cycle.
  - X_stall = X_re and not (granted to X and L2 completion this cycle).
  - X_stall is combinational, so it rises in the same cycle X_re rises.
- FSM states:
  - IDLE: l2_re=0. If any request is present, choose a winner, latch its address with the low log2(BLOCK_W/8) bits zeroed, and go to BUSY_I or BUSY_D next cycle. Grant latency is one cycle.
  - BUSY_I / BUSY_D: l2_re=1, l2_addr=latched address. On completion, forward l2_block to the owner.
    - If the other requester is pending: switch directly to its BUSY state, no idle bubble.
    - Else if the same requester is re-requesting: go to IDLE. Same-cycle re-request is not treated as new.
    - Else: go to IDLE.
- Round-robin:
  - A 1-bit last_grant register is updated on each grant.
  - When both requests arrive in the same IDLE cycle, the requester not granted last wins.
  - After reset, last_grant=D, so I wins the first tie.
- Abandon:
  - If the owner drops X_re mid-transaction (e.g. icache flushed on mispredict), the L2 transaction still runs to completion.
  - The data is discarded: X_block is not updated and X_stall stays 0 because X_re=0.
  - Changes on X_addr after grant are ignored.
- Outputs:
  - i_block/d_block are registered.
  - Each updates only in its owner's completion cycle and otherwise holds its value.
  - The combinational completion path drives the data to the owner in the completion cycle itself.
- Reset values: state=IDLE, l2_re=0, l2_addr=0, i_block=0, d_block=0, last_grant=D. i_stall/d_stall follow their formula.
- Reset mid-transaction: returns to IDLE immediately, and l2_re drops asynchronously. L2 is reset by the same rst_n.
- The arbiter never issues two outstanding L2 reads.

Optional Feature:
- Macro: L2ARB_PERF_EN.
- Defined:
  - Adds outputs perf_i_grants[31:0], perf_d_grants[31:0] and perf_conflict[31:0].
  - perf_conflict counts cycles where both X_re=1 and both stalls=1.
  - Counters are saturating, reset to 0, and increment at grant or per cycle as named.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package l2_arb_pkg: typedef enum arb_state_t {IDLE, BUSY_I, BUSY_D}; typedef enum requester_t {REQ_I, REQ_D}; localparam BLOCK_OFFSET_W = $clog2(BLOCK_W/8).
- Sub-module rr_arbiter2: 2-input round-robin picker.
  - Inputs: req[1:0], last_grant.
  - Output: grant_onehot.
  - Purely combinational plus the last_grant flop.

Test Plan:
- i_re=1, i_addr=0x0000_1234, L2 stalls 3 cycles → l2_addr=0x0000_1220 from cycle 1; i_stall=1 until completion; i_block equals l2_block; d_stall=0 throughout.
- i_re and d_re both rise the same cycle after reset → I served first; D granted in the cycle after I completes (no IDLE); next tie goes to D.
- d_re held continuously for 4 back-to-back blocks while i_re is also held → grants alternate I, D, I, D; neither starves.
- icache drops i_re two cycles into an I transaction → l2_re held until completion; i_block unchanged; a pending D is granted next.
- Async rst_n asserted while BUSY_D with l2_stall=1 → l2_re=0 immediately; after release, state IDLE and d_stall follows d_re.
- L2ARB_PERF_EN build, 5 I refills, 3 D refills, 4 overlap cycles → perf_i_grants=5, perf_d_grants=3, perf_conflict=4.

Source files
------------

// File: rtl/l2_arb_pkg.sv
// ----------------------------------------------------------------------------
// l2_arb_pkg
//
// Shared types and constants for the L2 read-port arbiter.
//
// Contents:
//   arb_state_t     - arbiter FSM states (IDLE, BUSY_I, BUSY_D)
//   requester_t     - identity of a refill requester (REQ_I, REQ_D); the
//                     enum value doubles as the bit index into the 2-bit
//                     request / grant vectors
//   BLOCK_W_DEFAULT - default refill block width in bits
//   BLOCK_OFFSET_W  - byte-offset bits inside a default-width block
//   PERF_CNT_W      - width of the optional performance counters
//   block_offset_w  - helper returning the byte-offset width for any block
//                     width, so the top stays correct when BLOCK_W is
//                     overridden
// ----------------------------------------------------------------------------
package l2_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } arb_state_t;

   typedef enum logic {
      REQ_I = 1'b0,
      REQ_D = 1'b1
   } requester_t;

   localparam int BLOCK_W_DEFAULT = 256;
   localparam int BLOCK_OFFSET_W  = $clog2(BLOCK_W_DEFAULT / 8);
   localparam int PERF_CNT_W      = 32;

   // Number of low address bits that select a byte inside one block.
   function automatic int block_offset_w(input int block_w);
      return $clog2(block_w / 8);
   endfunction

endpackage : l2_arb_pkg

// File: rtl/l2_read_arbiter_rr.sv
// ----------------------------------------------------------------------------
// rr_arbiter2
//
// Two-input round-robin picker with its own last-grant memory.
//
// Ports:
//   clk           in   clock
//   rst_n         in   asynchronous active-low reset
//   req[1:0]      in   request vector, bit REQ_I = icache, bit REQ_D = dcache
//   grant_onehot  out  one-hot grant (all zero when req is zero)
//
// The grant is purely combinational from req and the last-grant flop. The
// flop records the winner every cycle in which any request is presented, so
// the caller must only present requests in cycles where a grant is taken.
// Reset leaves last_grant at REQ_D so the icache wins the first tie.
// ----------------------------------------------------------------------------
module rr_arbiter2
   import l2_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   output logic [1:0] grant_onehot
);

   requester_t last_grant_q;
   requester_t last_grant_d;

   // A lone request always wins; a tie goes to whoever was not served last.
   always_comb begin
      grant_onehot = 2'b00;
      if (req[REQ_I] && req[REQ_D]) begin
         if (last_grant_q == REQ_D) begin
            grant_onehot[REQ_I] = 1'b1;
         end else begin
            grant_onehot[REQ_D] = 1'b1;
         end
      end else if (req[REQ_I]) begin
         grant_onehot[REQ_I] = 1'b1;
      end else if (req[REQ_D]) begin
         grant_onehot[REQ_D] = 1'b1;
      end
   end

   always_comb begin
      last_grant_d = last_grant_q;
      if (grant_onehot[REQ_D]) begin
         last_grant_d = REQ_D;
      end else if (grant_onehot[REQ_I]) begin
         last_grant_d = REQ_I;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= REQ_D;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule : rr_arbiter2

// File: rtl/l2_read_arbiter.sv
// ----------------------------------------------------------------------------
// l2_read_arbiter
//
// Shares the single L2 read port between the icache refill path (fetch) and
// the dcache refill path (memory stage). One block read is in flight at a
// time; the granted address is latched block-aligned and held on the L2 port
// until completion (l2_re=1 and l2_stall=0), when the returned block is
// routed to the owner.
//
// Parameters:
//   ADDR_W   byte address width
//   BLOCK_W  refill block width in bits
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   i_re, i_addr          icache refill request (level) and address
//   i_block, i_stall      block to icache, icache stall
//   d_re, d_addr          dcache refill request (level) and address
//   d_block, d_stall      block to dcache, dcache stall
//   l2_re, l2_addr        read enable and block-aligned address to L2
//   l2_block, l2_stall    L2 read data (valid at completion), L2 busy
//
// Optional build macro L2ARB_PERF_EN adds saturating counters:
//   perf_i_grants, perf_d_grants  grants given to each requester
//   perf_conflict                 cycles with both requesters stalled
//
// A requester that drops its request while it owns the L2 port abandons the
// read: the L2 transaction still completes (L2 cannot be cancelled), but
// the block is thrown away and that requester's block output keeps its
// previous value.
// ----------------------------------------------------------------------------
module l2_read_arbiter
   import l2_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int BLOCK_W = BLOCK_W_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_re,
   input  logic [ADDR_W-1:0]  i_addr,
   output logic [BLOCK_W-1:0] i_block,
   output logic               i_stall,
   input  logic               d_re,
   input  logic [ADDR_W-1:0]  d_addr,
   output logic [BLOCK_W-1:0] d_block,
   output logic               d_stall,
   output logic               l2_re,
   output logic [ADDR_W-1:0]  l2_addr,
   input  logic [BLOCK_W-1:0] l2_block,
   input  logic               l2_stall
`ifdef L2ARB_PERF_EN
   ,
   output logic [PERF_CNT_W-1:0] perf_i_grants,
   output logic [PERF_CNT_W-1:0] perf_d_grants,
   output logic [PERF_CNT_W-1:0] perf_conflict
`endif
);

   localparam int OFF_W = block_offset_w(BLOCK_W);
   localparam logic [ADDR_W-1:0] OFF_MASK = {{(ADDR_W - OFF_W){1'b0}}, {OFF_W{1'b1}}};

   arb_state_t         state_q,   state_d;
   logic               l2_re_q,   l2_re_d;
   logic [ADDR_W-1:0]  l2_addr_q, l2_addr_d;
   logic [BLOCK_W-1:0] i_block_q, i_block_d;
   logic [BLOCK_W-1:0] d_block_q, d_block_d;

   logic       completion;
   logic       i_done;
   logic       d_done;
   logic [1:0] arb_req;
   logic [1:0] grant_onehot;
   logic       grant_i;
   logic       grant_d;

   // Completion is taken from the registered l2_re, so it can only occur
   // while one of the BUSY states owns the port.
   assign completion = l2_re_q & ~l2_stall;
   assign i_done     = completion & (state_q == BUSY_I);
   assign d_done     = completion & (state_q == BUSY_D);

   assign i_stall = i_re & ~i_done;
   assign d_stall = d_re & ~d_done;

   // Requests are shown to the picker only when a new owner may be chosen:
   // in IDLE, or in the owner's completion cycle. At completion only the
   // other requester is offered, so a same-cycle re-request from the owner
   // is not taken as new and falls back through IDLE instead.
   always_comb begin
      arb_req = 2'b00;
      if (state_q == IDLE) begin
         arb_req = {d_re, i_re};
      end else if (i_done) begin
         arb_req = {d_re, 1'b0};
      end else if (d_done) begin
         arb_req = {1'b0, i_re};
      end
   end

   rr_arbiter2 u_rr (
      .clk          (clk),
      .rst_n        (rst_n),
      .req          (arb_req),
      .grant_onehot (grant_onehot)
   );

   assign grant_i = grant_onehot[REQ_I];
   assign grant_d = grant_onehot[REQ_D];

   // Next-state and L2 port: a grant (from IDLE or as a direct hand-over at
   // completion) loads the new owner's aligned address; a completion with no
   // follow-on grant releases the port.
   always_comb begin
      state_d   = state_q;
      l2_re_d   = l2_re_q;
      l2_addr_d = l2_addr_q;
      if (grant_i) begin
         state_d   = BUSY_I;
         l2_re_d   = 1'b1;
         l2_addr_d = i_addr & ~OFF_MASK;
      end else if (grant_d) begin
         state_d   = BUSY_D;
         l2_re_d   = 1'b1;
         l2_addr_d = d_addr & ~OFF_MASK;
      end else if (completion) begin
         state_d   = IDLE;
         l2_re_d   = 1'b0;
      end
   end

   // Block capture happens only when the owner is still asking for it; an
   // abandoned read leaves the old block in place.
   always_comb begin
      i_block_d = i_block_q;
      d_block_d = d_block_q;
      if (i_done && i_re) begin
         i_block_d = l2_block;
      end
      if (d_done && d_re) begin
         d_block_d = l2_block;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         l2_re_q   <= 1'b0;
         l2_addr_q <= '0;
         i_block_q <= '0;
         d_block_q <= '0;
      end else begin
         state_q   <= state_d;
         l2_re_q   <= l2_re_d;
         l2_addr_q <= l2_addr_d;
         i_block_q <= i_block_d;
         d_block_q <= d_block_d;
      end
   end

   assign l2_re   = l2_re_q;
   assign l2_addr = l2_addr_q;

   // The block outputs show the incoming L2 data in the completion cycle
   // itself and the captured copy afterwards.
   assign i_block = i_block_d;
   assign d_block = d_block_d;

`ifdef L2ARB_PERF_EN
   logic [PERF_CNT_W-1:0] perf_i_grants_q, perf_i_grants_d;
   logic [PERF_CNT_W-1:0] perf_d_grants_q, perf_d_grants_d;
   logic [PERF_CNT_W-1:0] perf_conflict_q, perf_conflict_d;

   // Saturating counters: they stop at all-ones rather than wrapping.
   always_comb begin
      perf_i_grants_d = perf_i_grants_q;
      perf_d_grants_d = perf_d_grants_q;
      perf_conflict_d = perf_conflict_q;
      if (grant_i && (perf_i_grants_q != '1)) begin
         perf_i_grants_d = perf_i_grants_q + 1'b1;
      end
      if (grant_d && (perf_d_grants_q != '1)) begin
         perf_d_grants_d = perf_d_grants_q + 1'b1;
      end
      if (i_re && d_re && i_stall && d_stall && (perf_conflict_q != '1)) begin
         perf_conflict_d = perf_conflict_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_i_grants_q <= '0;
         perf_d_grants_q <= '0;
         perf_conflict_q <= '0;
      end else begin
         perf_i_grants_q <= perf_i_grants_d;
         perf_d_grants_q <= perf_d_grants_d;
         perf_conflict_q <= perf_conflict_d;
      end
   end

   assign perf_i_grants = perf_i_grants_q;
   assign perf_d_grants = perf_d_grants_q;
   assign perf_conflict = perf_conflict_q;
`endif

endmodule : l2_read_arbiter

// File: tb/tb_l2_read_arbiter.sv
// ----------------------------------------------------------------------------
// tb_l2_read_arbiter
//
// Directed bench for l2_read_arbiter. The bench plays the L2 and both
// requesters. Each block it returns at an L2 completion is pushed onto a
// scoreboard together with the requester that should receive it; the block
// is popped when the expected requester sees data, and the DUT's block
// output is compared against it. Stalls, l2_re and l2_addr are checked every
// cycle against the bench's own expectations.
// ----------------------------------------------------------------------------
module tb_l2_read_arbiter;
   import l2_arb_pkg::*;

   localparam int ADDR_W  = 32;
   localparam int BLOCK_W = 256;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               i_re, d_re;
   logic [ADDR_W-1:0]  i_addr, d_addr;
   logic [BLOCK_W-1:0] i_block, d_block;
   logic               i_stall, d_stall;
   logic               l2_re;
   logic [ADDR_W-1:0]  l2_addr;
   logic [BLOCK_W-1:0] l2_block;
   logic               l2_stall;
`ifdef L2ARB_PERF_EN
   logic [31:0] perf_i_grants, perf_d_grants, perf_conflict;
`endif

   always #5 clk = ~clk;

   l2_read_arbiter #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_re     (i_re),
      .i_addr   (i_addr),
      .i_block  (i_block),
      .i_stall  (i_stall),
      .d_re     (d_re),
      .d_addr   (d_addr),
      .d_block  (d_block),
      .d_stall  (d_stall),
      .l2_re    (l2_re),
      .l2_addr  (l2_addr),
      .l2_block (l2_block),
      .l2_stall (l2_stall)
`ifdef L2ARB_PERF_EN
      ,
      .perf_i_grants (perf_i_grants),
      .perf_d_grants (perf_d_grants),
      .perf_conflict (perf_conflict)
`endif
   );

   typedef struct {
      requester_t         owner;
      logic [BLOCK_W-1:0] data;
   } sb_item_t;

   sb_item_t sb_q[$];

   int n_compared   = 0;
   int n_mismatched = 0;

   logic               exp_l2_re;
   logic [ADDR_W-1:0]  exp_l2_addr;
   logic [BLOCK_W-1:0] exp_i_block, exp_d_block;
   logic               comp_flag;
   requester_t         comp_owner;
   int                 exp_i_grants, exp_d_grants, exp_conflict;

   task automatic check(input string tag, input logic [BLOCK_W-1:0] obs,
                        input logic [BLOCK_W-1:0] exp);
      n_compared++;
      assert (obs === exp) else begin
         n_mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [BLOCK_W-1:0] rand_block();
      logic [BLOCK_W-1:0] r;
      for (int w = 0; w < BLOCK_W / 32; w++) begin
         r[w*32 +: 32] = $urandom();
      end
      return r;
   endfunction

   // One clock: check everything at the falling edge, then return just
   // after the next rising edge so the caller can drive new inputs.
   task automatic tick();
      logic     is_exp, ds_exp;
      sb_item_t it;
      @(negedge clk);
      is_exp = i_re & ~(comp_flag & (comp_owner == REQ_I));
      ds_exp = d_re & ~(comp_flag & (comp_owner == REQ_D));
      check("i_stall", i_stall, is_exp);
      check("d_stall", d_stall, ds_exp);
      check("l2_re", l2_re, exp_l2_re);
      if (exp_l2_re) check("l2_addr", l2_addr, exp_l2_addr);
      if (i_re && !is_exp) begin
         if (sb_q.size() == 0) begin
            check("sb_depth_i", sb_q.size(), 1);
         end else begin
            it = sb_q.pop_front();
            check("sb_owner_i", it.owner, REQ_I);
            exp_i_block = it.data;
         end
      end
      if (d_re && !ds_exp) begin
         if (sb_q.size() == 0) begin
            check("sb_depth_d", sb_q.size(), 1);
         end else begin
            it = sb_q.pop_front();
            check("sb_owner_d", it.owner, REQ_D);
            exp_d_block = it.data;
         end
      end
      check("i_block", i_block, exp_i_block);
      check("d_block", d_block, exp_d_block);
      if (rst_n && i_re && d_re && is_exp && ds_exp) exp_conflict++;
      @(posedge clk);
      #1;
   endtask

   // Act as L2 for one granted read: stall a number of cycles, then
   // complete with a fresh random block.
   task automatic l2_serve(input requester_t owner, input logic [ADDR_W-1:0] addr,
                           input int stalls, input bit handoff);
      logic [BLOCK_W-1:0] blk;
      exp_l2_re   = 1'b1;
      exp_l2_addr = addr;
      if (owner == REQ_I) exp_i_grants++;
      else                exp_d_grants++;
      for (int k = 0; k < stalls; k++) begin
         l2_stall = 1'b1;
         l2_block = rand_block();
         tick();
      end
      blk        = rand_block();
      l2_stall   = 1'b0;
      l2_block   = blk;
      comp_flag  = 1'b1;
      comp_owner = owner;
      if (handoff) sb_q.push_back('{owner, blk});
      tick();
      comp_flag = 1'b0;
      l2_stall  = 1'b1;
      l2_block  = rand_block();
      exp_l2_re = 1'b0;
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      comp_flag   = 1'b0;
      l2_stall    = 1'b1;
      exp_l2_re   = 1'b0;
      exp_i_block = '0;
      exp_d_block = '0;
      #2;
      check("rst_l2_re", l2_re, 1'b0);
      check("rst_l2_addr", l2_addr, '0);
      check("rst_i_block", i_block, '0);
      check("rst_d_block", d_block, '0);
      check("rst_i_stall", i_stall, i_re);
      check("rst_d_stall", d_stall, d_re);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n        = 1'b1;
      exp_i_grants = 0;
      exp_d_grants = 0;
      exp_conflict = 0;
   endtask

   initial begin
      rst_n      = 1'b0;
      i_re       = 1'b0;
      d_re       = 1'b0;
      i_addr     = '0;
      d_addr     = '0;
      l2_block   = '0;
      l2_stall   = 1'b1;
      comp_flag  = 1'b0;
      comp_owner = REQ_I;
      do_reset();

      $display("[TB] single icache refill with 3 L2 stall cycles");
      i_re   = 1'b1;
      i_addr = 32'h0000_1234;
      tick();
      l2_serve(REQ_I, 32'h0000_1220, 3, 1'b1);
      i_re = 1'b0;
      tick();

      $display("[TB] tie after reset, then alternating back-to-back refills");
      do_reset();
      i_re   = 1'b1;
      d_re   = 1'b1;
      i_addr = 32'h0000_ABCD;
      d_addr = 32'h8000_0047;
      tick();
      l2_serve(REQ_I, 32'h0000_ABC0, 2, 1'b1);
      i_addr = 32'h0000_2000;
      l2_serve(REQ_D, 32'h8000_0040, 1, 1'b1);
      d_addr = 32'h8000_1FFF;
      l2_serve(REQ_I, 32'h0000_2000, 0, 1'b1);
      i_re = 1'b0;
      l2_serve(REQ_D, 32'h8000_1FE0, 2, 1'b1);
      d_re = 1'b0;
      tick();
      i_re   = 1'b1;
      d_re   = 1'b1;
      i_addr = 32'h0000_0040;
      d_addr = 32'h0000_0060;
      tick();
      l2_serve(REQ_I, 32'h0000_0040, 1, 1'b1);
      i_re = 1'b0;
      l2_serve(REQ_D, 32'h0000_0060, 1, 1'b1);
      d_re = 1'b0;
      tick();

      $display("[TB] icache abandons its refill, pending dcache follows");
      i_re   = 1'b1;
      i_addr = 32'h0000_3000;
      tick();
      exp_l2_re   = 1'b1;
      exp_l2_addr = 32'h0000_3000;
      tick();
      tick();
      i_re   = 1'b0;
      i_addr = 32'hFFFF_FFFF;
      d_re   = 1'b1;
      d_addr = 32'h0000_5000;
      l2_serve(REQ_I, 32'h0000_3000, 1, 1'b0);
      l2_serve(REQ_D, 32'h0000_5000, 1, 1'b1);
      d_re = 1'b0;
      tick();

      $display("[TB] asynchronous reset while dcache read is stalled");
      d_re   = 1'b1;
      d_addr = 32'h0000_7010;
      tick();
      exp_l2_re   = 1'b1;
      exp_l2_addr = 32'h0000_7000;
      tick();
      do_reset();
      tick();
      l2_serve(REQ_D, 32'h0000_7000, 1, 1'b1);
      d_re = 1'b0;
      tick();
      tick();

`ifdef L2ARB_PERF_EN
      check("perf_i_grants", perf_i_grants, exp_i_grants);
      check("perf_d_grants", perf_d_grants, exp_d_grants);
      check("perf_conflict", perf_conflict, exp_conflict);
`endif
      check("sb_left", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule : tb_l2_read_arbiter
